dmem_responder: RTL and testbench

//   Multi-cycle data-memory responder for the pipelined MIPS core. It answers the core's

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle, word-addressed data memory for the pipelined MIPS core.
//   A request is accepted in IDLE. The responder spends WAIT_CYCLES cycles in
//   WAIT and then raises resp_valid for a single RESP cycle. A store commits
//   to the array at the clock edge that ends RESP. A load returns the word
//   read at the edge that enters RESP.
//
//   Optional build macro: DMEM_ALIGN_CHECK_EN
//     defined   - a misaligned address (addr[1:0] != 0) completes with
//                 resp_err=1, resp_rdata=0 and no array write
//     undefined - addr[1:0] is ignored and resp_err is always 0
//
// Ports
//   clk         in   1   system clock, rising edge
//   rst         in   1   synchronous active-high reset (array contents kept)
//   req_valid   in   1   request present
//   req_write   in   1   1 = store, 0 = load
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data
//   req_ready   out  1   request can be accepted this cycle (IDLE)
//   resp_valid  out  1   one-cycle completion pulse
//   resp_rdata  out  32  load data, zero outside a load response
//   resp_err    out  1   alignment error, meaningful with resp_valid only
//   busy        out  1   transaction in flight (WAIT or RESP)

module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          write_q, write_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   mem_rdata_q;
  logic [AW-1:0] rd_idx;
  logic          mem_we;
  logic          misaligned;

  // Address bits above the word index, and the byte offset, never reach
  // the array; addresses wrap modulo 4*DEPTH_WORDS bytes.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    write_d = write_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          write_d = req_write;
          err_d   = misaligned;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // The read port runs every cycle. The value held during RESP is the one
  // read at the edge entering RESP. With zero wait states that edge is the
  // acceptance edge, so the live request address must be used while IDLE.
  assign rd_idx = (state_q == S_IDLE) ? req_addr[AW+1:2] : idx_q;

  // Gating with rst keeps a reset that lands in RESP from committing the store.
  assign mem_we = (state_q == S_RESP) && write_q && !err_q && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
    mem_rdata_q <= mem[rd_idx];
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = (state_q == S_RESP) && err_q;
  assign resp_rdata = ((state_q == S_RESP) && !write_q && !err_q) ? mem_rdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Instance with two wait states
  logic        v2 = 1'b0, w2 = 1'b0;
  logic [31:0] a2 = '0, d2 = '0;
  logic        rdy2, rv2, er2, bz2;
  logic [31:0] rd2;

  // Instance with zero wait states
  logic        v0 = 1'b0, w0 = 1'b0;
  logic [31:0] a0 = '0, d0 = '0;
  logic        rdy0, rv0, er0, bz0;
  logic [31:0] rd0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_write(w2), .req_addr(a2),
    .req_wdata(d2), .req_ready(rdy2), .resp_valid(rv2), .resp_rdata(rd2),
    .resp_err(er2), .busy(bz2)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_write(w0), .req_addr(a0),
    .req_wdata(d0), .req_ready(rdy0), .resp_valid(rv0), .resp_rdata(rd0),
    .resp_err(er0), .busy(bz0)
  );

  // One row = inputs driven during one cycle plus the outputs expected in
  // that same cycle. sel picks the instance (0: two waits, 1: zero waits).
  typedef struct {
    bit          sel;
    bit          rst;
    bit          vld;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk;
    bit          ready;
    bit          rvalid;
    logic [31:0] rdata;
    bit          err;
    bit          busy;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(bit sel, bit r, bit vld, bit wr, logic [31:0] addr,
                              logic [31:0] wdata, bit chk, bit ready, bit rvalid,
                              logic [31:0] rdata, bit err, bit busy);
    vec_t x;
    x.sel = sel; x.rst = r; x.vld = vld; x.wr = wr; x.addr = addr; x.wdata = wdata;
    x.chk = chk; x.ready = ready; x.rvalid = rvalid; x.rdata = rdata; x.err = err;
    x.busy = busy;
    return x;
  endfunction

  // Request row: responder idle, request presented
  function automatic vec_t req(bit sel, bit wr, logic [31:0] addr, logic [31:0] wdata);
    return mk(sel, 1'b0, 1'b1, wr, addr, wdata, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t wt(bit sel);
    return mk(sel, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
  endfunction

  function automatic vec_t rsp(bit sel, logic [31:0] rdata, bit err);
    return mk(sel, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, rdata, err, 1'b1);
  endfunction

  function automatic vec_t idle(bit sel);
    return mk(sel, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
  endfunction

  // Full transaction on the two-wait instance: accept, 2 x WAIT, RESP
  task automatic txn2(bit wr, logic [31:0] addr, logic [31:0] wdata,
                      logic [31:0] rdata, bit err);
    tbl.push_back(req(1'b0, wr, addr, wdata));
    tbl.push_back(wt(1'b0));
    tbl.push_back(wt(1'b0));
    tbl.push_back(rsp(1'b0, rdata, err));
  endtask

  task automatic check_bit(string name, bit act, bit req_v);
    n_vec++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req_v);
    end
  endtask

  // One transaction on the zero-wait instance with a bounded wait for the
  // response; optionally asserts rst during the RESP cycle.
  task automatic txn0(bit wr, logic [31:0] addr, logic [31:0] wdata, bit abort,
                      output logic [31:0] rdata, output bit got);
    got   = 1'b0;
    rdata = 32'hx;
    @(posedge clk); #1;
    v0 = 1'b1; w0 = wr; a0 = addr; d0 = wdata;
    @(posedge clk); #1;
    v0 = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (rv0) begin
        got   = 1'b1;
        rdata = rd0;
        if (abort) rst = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] hd;
    bit          hg;
    logic [35:0] act, exp;

    // Reset held for two cycles
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 32'd0, 0, 0));
    // Store 0xDEADBEEF @0x10; a changed request while busy must be ignored
    tbl.push_back(req(0, 1'b1, 32'h10, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 1, 1, 32'h14, 32'h11111111, 1, 0, 0, 32'd0, 0, 1));
    tbl.push_back(wt(0));
    tbl.push_back(rsp(0, 32'd0, 1'b0));
    txn2(1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    // Address wrap: 0x400 aliases word 0
    txn2(1'b1, 32'h400, 32'h1234, 32'd0, 1'b0);
    txn2(1'b0, 32'h000, 32'd0, 32'h1234, 1'b0);
    // Abort: word 8 holds 0, a store aborted by reset in WAIT leaves it 0
    txn2(1'b1, 32'h20, 32'd0, 32'd0, 1'b0);
    tbl.push_back(req(0, 1'b1, 32'h20, 32'hA5A5A5A5));
    tbl.push_back(wt(0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 32'd0, 0, 1));
    // rst together with req_valid: reset wins, request not taken
    tbl.push_back(mk(0, 1, 1, 0, 32'h20, 0, 1, 1, 0, 32'd0, 0, 0));
    tbl.push_back(idle(0));
    txn2(1'b0, 32'h20, 32'd0, 32'd0, 1'b0);
    // Misaligned accesses
    txn2(1'b0, 32'h13, 32'd0, ALIGN_ON ? 32'd0 : 32'hDEADBEEF, ALIGN_ON);
    txn2(1'b1, 32'h22, 32'h77777777, 32'd0, ALIGN_ON);
    txn2(1'b0, 32'h20, 32'd0, ALIGN_ON ? 32'd0 : 32'h77777777, 1'b0);
    // Top word and its wrapped alias
    txn2(1'b1, 32'h3FC, 32'hCAFEF00D, 32'd0, 1'b0);
    txn2(1'b0, 32'h7FC, 32'd0, 32'hCAFEF00D, 1'b0);
    tbl.push_back(idle(0));
    // Zero wait states: response one cycle after acceptance, and with
    // req_valid held high a request is accepted every second cycle
    tbl.push_back(req(1, 1'b1, 32'h0, 32'h55AA));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0, 0, 1, 0, 1, 32'd0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'd0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0, 0, 1, 0, 1, 32'h55AA, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'd0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0, 0, 1, 0, 1, 32'h55AA, 0, 1));
    tbl.push_back(idle(1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      rst = tbl[i].rst;
      if (tbl[i].sel) begin
        v2 = 1'b0;
        v0 = tbl[i].vld; w0 = tbl[i].wr; a0 = tbl[i].addr; d0 = tbl[i].wdata;
      end else begin
        v0 = 1'b0;
        v2 = tbl[i].vld; w2 = tbl[i].wr; a2 = tbl[i].addr; d2 = tbl[i].wdata;
      end
      if (tbl[i].chk) begin
        n_vec++;
        act = tbl[i].sel ? {rdy0, rv0, rd0, er0, bz0} : {rdy2, rv2, rd2, er2, bz2};
        exp = {tbl[i].ready, tbl[i].rvalid, tbl[i].rdata, tbl[i].err, tbl[i].busy};
        if (act !== exp) begin
          n_fail++;
          $display("FAIL vec%0d dut%0d: got rdy=%b rv=%b rdata=%h err=%b busy=%b, required rdy=%b rv=%b rdata=%h err=%b busy=%b",
                   i, tbl[i].sel ? 0 : 2, act[35], act[34], act[33:2], act[1], act[0],
                   exp[35], exp[34], exp[33:2], exp[1], exp[0]);
        end
      end
    end
    v0 = 1'b0; v2 = 1'b0; rst = 1'b0;

    // Reset landing in RESP must suppress the store commit
    txn0(1'b1, 32'h40, 32'h11111111, 1'b0, hd, hg);
    check_bit("store_0x40_resp", hg, 1'b1);
    txn0(1'b1, 32'h40, 32'h99999999, 1'b1, hd, hg);
    check_bit("aborted_store_resp", hg, 1'b1);
    txn0(1'b0, 32'h40, 32'd0, 1'b0, hd, hg);
    check_bit("load_0x40_resp", hg, 1'b1);
    n_vec++;
    if (hd !== 32'h11111111) begin
      n_fail++;
      $display("FAIL load_0x40_after_abort: got %h, required %h", hd, 32'h11111111);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
